// File: rtl/rf_pkg.sv
// Shared register-file constants and helpers, reused by decode and hazard units.
//   RF_XLEN  : default register width
//   RF_NREGS : default architectural register count
//   rf_aw()  : address width needed for a register count (never below 1)
package rf_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  function automatic int rf_aw(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set at issue, cleared at writeback.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   iss_en, iss_addr    destination being issued (sets pending)
//   wb_en, wb_addr      register being written back (clears pending)
//   flush               clears every pending bit, drops a concurrent issue
//   pending             registered pending vector
//   any_busy            OR of all pending bits
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS    = RF_NREGS,
  parameter int ZERO_REG = 1,
  localparam int AW      = rf_aw(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic             flush,
  output logic [NREGS-1:0] pending,
  output logic             any_busy
);

  logic [NREGS-1:0] pending_nxt;
  logic             iss_ok;

  assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

  // Clear before set so a new producer issued on the retiring register wins.
  always_comb begin
    pending_nxt = pending;
    if (flush) begin
      pending_nxt = '0;
    end else begin
      if (wb_en)  pending_nxt[wb_addr]  = 1'b0;
      if (iss_ok) pending_nxt[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign any_busy = |pending;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file with write-to-read bypass and scoreboard.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ra      [NRD*AW]           read addresses, port i at [i*AW +: AW]
//   rdata   [NRD*XLEN]         combinational read data, port i at [i*XLEN +: XLEN]
//   rbusy   [NRD]              read register has a pending producer
//   wb_en, wb_addr, wb_data    writeback
//   iss_en, iss_addr           issue of an instruction writing iss_addr
//   flush                      clears all pending bits
//   any_busy                   OR of all pending bits (no bypass masking)
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = rf_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic                any_busy
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic             wr_ok;

  assign wr_ok = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wr_ok) begin
      regs[wb_addr] <= wb_data;
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .flush    (flush),
    .pending  (pending),
    .any_busy (any_busy)
  );

  // Busy lookup sits here so the bypass that forwards data also masks busy.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero;
    logic          is_byp;

    assign addr    = ra[gi*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign is_byp  = (BYPASS != 0) && wb_en && (wb_addr == addr);

    assign rdata[gi*XLEN +: XLEN] = is_zero ? '0 : (is_byp ? wb_data : regs[addr]);
    assign rbusy[gi]              = !is_zero && !is_byp && pending[addr];
  end

endmodule
